// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous BCD shadow, blink and lead-zero blanking.
// Optional brightness windowing is enabled by defining DISPLAY_DIMMING_EN (adds the Bright port).
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 64,
    parameter int BLINK_DIV  = 500,
    parameter int CNT_W      = 16
) (
    input  logic                    Clk,
    input  logic                    Clr,
    input  logic                    Sel,
    input  logic [4*NUM_DIGITS-1:0] Cur_BCD,
    input  logic [4*NUM_DIGITS-1:0] Set_BCD,
    input  logic                    Upd,
    input  logic [NUM_DIGITS-1:0]   Blink_Mask,
    input  logic                    Blank_Lead,
`ifdef DISPLAY_DIMMING_EN
    input  logic [3:0]              Bright,
`endif
    output logic [6:0]              Seg,
    output logic [NUM_DIGITS-1:0]   Dig_En,
    output logic                    Blink,
    output logic                    Frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SCAN_TC  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLINK_TC = CNT_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        scnt;
    logic [CNT_W-1:0]        bcnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;
    logic                    frame_tc;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    lz_run;
    logic [3:0]              cur_nib;
    logic                    seg_off;
    logic                    en;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    assign frame_tc = (idx == IDX_LAST) && (scnt == SCAN_TC);
    assign Frame    = frame_tc;
    assign cur_nib  = shadow[4*int'(idx) +: 4];

    // lead_zero[i] is set when digit i and every more-significant digit are zero
    always_comb begin
        lead_zero = '0;
        lz_run    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run       = lz_run && (shadow[4*i +: 4] == 4'd0);
            lead_zero[i] = lz_run;
        end
    end

    assign seg_off = (Blink_Mask[idx] && Blink) ||
                     (Blank_Lead && (idx != '0) && lead_zero[idx]);

`ifdef DISPLAY_DIMMING_EN
    logic [3:0] bright_q;
    int         on_end;

    // On-window ends (inclusive) after (Bright+1) sixteenths of the slot, never past the slot end
    always_comb begin
        on_end = (int'(bright_q) + 1) * (SCAN_DIV / 16);
        if (on_end > SCAN_DIV - 1)
            on_end = SCAN_DIV - 1;
        en = (scnt != '0) && (int'(scnt) <= on_end);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr)
            bright_q <= 4'd0;
        else if (scnt == '0)
            bright_q <= Bright;
    end
`else
    always_comb begin
        en = (scnt != '0);
    end
`endif

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            scnt    <= '0;
            bcnt    <= '0;
            idx     <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            Blink   <= 1'b0;
            Seg     <= '0;
            Dig_En  <= '0;
        end else begin
            if (bcnt == BLINK_TC) begin
                bcnt  <= '0;
                Blink <= ~Blink;
            end else begin
                bcnt <= bcnt + CNT_W'(1);
            end

            if (scnt == SCAN_TC) begin
                scnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                scnt <= scnt + CNT_W'(1);
            end

            // A request on the frame cycle itself loads at this same edge
            if (frame_tc && (pending || Upd)) begin
                shadow  <= Sel ? Set_BCD : Cur_BCD;
                pending <= 1'b0;
            end else if (Upd) begin
                pending <= 1'b1;
            end

            Dig_En <= en ? (NUM_DIGITS'(1) << idx) : '0;
            Seg    <= (en && !seg_off) ? seg_decode(cur_nib) : 7'h00;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8), default build.
module tb_display_scan_ctrl;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        Sel = 1'b0;
    logic [15:0] Cur_BCD = 16'h0000;
    logic [15:0] Set_BCD = 16'h0000;
    logic        Upd = 1'b0;
    logic [3:0]  Blink_Mask = 4'b0000;
    logic        Blank_Lead = 1'b0;
`ifdef DISPLAY_DIMMING_EN
    logic [3:0]  Bright = 4'd15;
`endif
    logic [6:0]  Seg;
    logic [3:0]  Dig_En;
    logic        Blink;
    logic        Frame;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    display_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8), .CNT_W(16)
    ) dut (
        .Clk(Clk), .Clr(Clr), .Sel(Sel), .Cur_BCD(Cur_BCD), .Set_BCD(Set_BCD),
        .Upd(Upd), .Blink_Mask(Blink_Mask), .Blank_Lead(Blank_Lead),
`ifdef DISPLAY_DIMMING_EN
        .Bright(Bright),
`endif
        .Seg(Seg), .Dig_En(Dig_En), .Blink(Blink), .Frame(Frame)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
    endtask

    // One 4-cycle digit slot: ghost cycle, then three cycles of digit d showing seg_on.
    // Upd is driven high for the single cycle preceding step upd_at (-1 = none).
    task automatic slot(input int d, input logic [6:0] seg_on, input int upd_at);
        for (int s = 0; s < 4; s++) begin
            Upd = (s == upd_at);
            step();
            Upd = 1'b0;
            check($sformatf("den d%0d s%0d", d, s), 32'(Dig_En), (s == 0) ? 32'd0 : 32'(1 << d));
            check($sformatf("seg d%0d s%0d", d, s), 32'(Seg), (s == 0) ? 32'd0 : 32'(seg_on));
            check($sformatf("frame d%0d s%0d", d, s), 32'(Frame), 32'((d == 3) && (s == 2)));
            check($sformatf("blink c%0d", cyc), 32'(Blink), 32'((cyc / 8) % 2));
        end
    endtask

    task automatic frame4(input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
        slot(0, s0, -1);
        slot(1, s1, -1);
        slot(2, s2, -1);
        slot(3, s3, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge Clk);
        check("rst seg", 32'(Seg), 32'd0);
        check("rst den", 32'(Dig_En), 32'd0);
        check("rst blink", 32'(Blink), 32'd0);
        check("rst frame", 32'(Frame), 32'd0);
        Clr = 1'b1;
        cyc = 0;

        // empty shadow, no lead blanking: every digit decodes 0
        frame4(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        frame4(7'h3F, 7'h3F, 7'h3F, 7'h3F);

        // mid-frame reload request takes effect only after the next Frame
        Cur_BCD = 16'h1234;
        slot(0, 7'h3F, -1);
        slot(1, 7'h3F, 0);
        slot(2, 7'h3F, -1);
        slot(3, 7'h3F, -1);
        Cur_BCD = 16'h9999;
        frame4(7'h66, 7'h4F, 7'h5B, 7'h06);

        // blink is phase-locked to the frame: digits 2/3 see Blink=1, digits 0/1 see Blink=0
        Blink_Mask = 4'b0011;
        frame4(7'h66, 7'h4F, 7'h5B, 7'h06);
        Blink_Mask = 4'b1100;
        frame4(7'h66, 7'h4F, 7'h00, 7'h00);
        Blink_Mask = 4'b0000;

        // leading-zero blanking
        Cur_BCD = 16'h0007;
        Blank_Lead = 1'b1;
        slot(0, 7'h66, 0);
        slot(1, 7'h4F, -1);
        slot(2, 7'h5B, -1);
        slot(3, 7'h06, -1);
        frame4(7'h07, 7'h00, 7'h00, 7'h00);

        Cur_BCD = 16'h0000;
        slot(0, 7'h07, 0);
        slot(1, 7'h00, -1);
        slot(2, 7'h00, -1);
        slot(3, 7'h00, -1);
        frame4(7'h3F, 7'h00, 7'h00, 7'h00);

        // non-BCD nibble decodes blank but still stops lead blanking below it
        Cur_BCD = 16'h0A00;
        slot(0, 7'h3F, 0);
        slot(1, 7'h00, -1);
        slot(2, 7'h00, -1);
        slot(3, 7'h00, -1);
        frame4(7'h3F, 7'h3F, 7'h00, 7'h00);
        Blank_Lead = 1'b0;
        frame4(7'h3F, 7'h3F, 7'h00, 7'h3F);

        // Upd exactly on the Frame cycle, Set source selected
        Sel = 1'b1;
        Set_BCD = 16'h0930;
        Cur_BCD = 16'h5678;
        slot(0, 7'h3F, -1);
        slot(1, 7'h3F, -1);
        slot(2, 7'h00, -1);
        slot(3, 7'h3F, 3);
        frame4(7'h3F, 7'h4F, 7'h6F, 7'h3F);
        Blank_Lead = 1'b1;
        frame4(7'h3F, 7'h4F, 7'h6F, 7'h00);

        // asynchronous reset in the middle of digit 2's slot
        slot(0, 7'h3F, -1);
        slot(1, 7'h4F, -1);
        step();
        step();
        check("pre-rst den", 32'(Dig_En), 32'h4);
        check("pre-rst blink", 32'(Blink), 32'd1);
        #2 Clr = 1'b0;
        #1;
        check("async rst seg", 32'(Seg), 32'd0);
        check("async rst den", 32'(Dig_En), 32'd0);
        check("async rst blink", 32'(Blink), 32'd0);
        check("async rst frame", 32'(Frame), 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        cyc = 0;
        frame4(7'h3F, 7'h00, 7'h00, 7'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
